stereo_peak_sample_scheduler: RTL and testbench
===============================================

# stereo_peak_sample_scheduler

Feeds a single shared section-peak datapath, which has one `i_valid/i_is_left/i_value` input port, from two independent, non-stallable channel sample sources: left and right, each delivered as single-cycle strobes. The block converts each signed sample to a saturated magnitude. It holds one pending sample per channel and grants the shared port round-robin under a valid/ready handshake. It counts samples lost to overrun per channel. It sits between the audio receiver (I2S deserializer) and the section-maximum stage.

## Interface
- `width`, 15: magnitude width presented downstream; input samples are `width+1` bits signed.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `i_left_valid`  in  1: one-cycle strobe, left sample present.
- `i_left_sample`  in  width+1: left sample, two's complement.
- `i_right_valid`  in  1: one-cycle strobe, right sample present.
- `i_right_sample`  in  width+1: right sample, two's complement.
- `o_valid`  out  1: output register holds a sample for the shared datapath.
- `o_ready`  in  1: downstream accepts; transfer when `o_valid && o_ready`.
- `o_is_left`  out  1: 1 = left channel, 0 = right.
- `o_value`  out  width: magnitude of the granted sample.
- `overrun_clear`  in  1: synchronous clear of both overrun counters.
- `overrun_left`  out  8: count of dropped left samples, saturating at 255.
- `overrun_right`  out  8: count of dropped right samples, saturating at 255.

## Operation
- Each channel has one holding register (`hold_full`, `hold_data`). The output stage is one register (`o_valid`, `o_is_left`, `o_value`).
- Capture: on a strobe, the sample is written into the channel hold if the hold is empty, or if the hold is being drained into the output this same cycle.
- Overrun: on a strobe while the hold is full and not draining this cycle:
  - the new sample is discarded and the held sample is kept;
  - the channel counter increments, saturating at 255.
- Output slot is free when `!o_valid || o_ready`. When free and at least one hold is full, exactly one hold is granted:
  - only one full: grant it;
  - both full: grant the channel named by the round-robin pointer `rr` (0 = left first).
- After any grant, `rr` points to the other channel. `rr` only changes on a grant.
- Granted load: `o_valid` <= 1, `o_is_left` <= channel, `o_value` <= |sample|, and the hold clears, unless it refills the same cycle per the capture rule.
- Free slot with no hold full: `o_valid` <= 0; `o_is_left` and `o_value` keep their values.
- Magnitude arithmetic: non-negative x gives x[width-1:0]. Negative x gives −x, except −2^width, which saturates to 2^width−1.
- `overrun_clear`: both counters become 0. An overrun in the same cycle leaves that channel's counter at 1 (the event is not lost).
- The downstream port is stalled only by `o_ready`. The input side never back-pressures.

## Timing
- Reset values: `o_valid`=0, `o_is_left`=0, `o_value`=0, `overrun_left`=0, `overrun_right`=0, holds empty, `rr`=left.
- Latency: strobe at edge N (hold written), output loaded at edge N+1 if the slot is free. `o_valid` is therefore high in the cycle after capture; there is no bypass path.
- Throughput: one grant per cycle while `o_ready`=1. Sustained simultaneous L+R strobes every cycle overflow. With strobes every ≥2 cycles per channel there is no loss.
- Simultaneous L+R strobes with both holds empty and `rr`=left: left is output at N+1, right at N+2.
- `o_ready` low: `o_valid`, `o_is_left`, `o_value` are stable until accepted. Holds keep capturing until full.
- Reset asserted mid-operation discards pending and output samples and zeroes counters asynchronously. The first strobe after release behaves as from power-up.

## Test plan
- Single left strobe, `i_left_sample`=16'hFF38 (−200), `o_ready`=1. Required: one cycle later `o_valid`=1, `o_is_left`=1, `o_value`=200. The next cycle `o_valid`=0.
- Simultaneous strobes, L=+1000, R=−1000, right after reset. Required: left/1000 appears first, right/1000 on the following cycle. Repeat with `rr`=right: right appears first.
- `o_ready`=0 for 10 cycles with 3 left strobes spaced 2 cycles apart. Required: output holds the first sample, the hold holds the second, the third is dropped, and `overrun_left`=1 with the output unchanged. Raise `o_ready`: the first two samples are delivered in order.
- Sample 16'h8000 on right. Required: `o_value`=15'h7FFF. Sample 16'h7FFF gives 15'h7FFF. Sample 0 gives 0.
- Force 300 left overruns. Required: `overrun_left`=255 (saturated). `overrun_clear` concurrent with one more overrun gives 1. `overrun_right` stays 0.
- Assert `reset` while `o_valid`=1 and both holds full. Required: all outputs go to 0 immediately. After release, a single right strobe gives right first, with no stale left sample emitted.

Source files
------------

// File: rtl/stereo_peak_sample_scheduler_if.sv
// Output port of the stereo sample scheduler towards the shared section-peak
// datapath. The scheduler drives the sample (master side); the datapath
// answers with o_ready (slave side).
// Handshake: a transfer happens on a rising edge where o_valid && o_ready;
// while o_valid is high and o_ready is low, o_is_left and o_value hold steady.
interface stereo_peak_sample_scheduler_if #(
   parameter int width = 15
);
   logic             o_valid;
   logic             o_ready;
   logic             o_is_left;
   logic [width-1:0] o_value;

   modport master (
      output o_valid,
      output o_is_left,
      output o_value,
      input  o_ready
   );

   modport slave (
      input  o_valid,
      input  o_is_left,
      input  o_value,
      output o_ready
   );
endinterface

// File: rtl/stereo_peak_sample_scheduler.sv
// Merges two non-stallable channel sample strobes (left/right) into one shared
// valid/ready port. Each channel has a single holding register; the output
// register is granted round-robin when both holds are full. Samples arriving
// at a full, non-draining hold are dropped and counted per channel.
module stereo_peak_sample_scheduler #(
   parameter int width = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_left_valid,
   input  logic [width:0]       i_left_sample,
   input  logic                 i_right_valid,
   input  logic [width:0]       i_right_sample,
   stereo_peak_sample_scheduler_if.master out_if,
   input  logic                 overrun_clear,
   output logic [7:0]           overrun_left,
   output logic [7:0]           overrun_right
);

   logic             hold_full_l;
   logic             hold_full_r;
   logic [width:0]   hold_data_l;
   logic [width:0]   hold_data_r;
   logic             rr;            // 0: left wins a tie, 1: right wins
   logic             slot_free;
   logic             grant_l;
   logic             grant_r;
   logic             capture_l;
   logic             capture_r;
   logic             overrun_l;
   logic             overrun_r;

   // Saturated magnitude: the most negative code has no positive twin and
   // is clamped to the largest representable magnitude.
   function automatic logic [width-1:0] magnitude(input logic [width:0] x);
      logic [width:0]   neg;
      logic [width-1:0] res;
      neg = ~x + {{width{1'b0}}, 1'b1};
      if (!x[width])
         res = x[width-1:0];
      else if (x[width-1:0] == '0)
         res = '1;
      else
         res = neg[width-1:0];
      return res;
   endfunction

   // Grant and capture decisions for the current cycle.
   always_comb begin
      slot_free = !out_if.o_valid || out_if.o_ready;
      grant_l   = 1'b0;
      grant_r   = 1'b0;
      if (slot_free) begin
         if (hold_full_l && hold_full_r) begin
            grant_l = !rr;
            grant_r = rr;
         end else begin
            grant_l = hold_full_l;
            grant_r = hold_full_r;
         end
      end
      capture_l = i_left_valid  && (!hold_full_l || grant_l);
      capture_r = i_right_valid && (!hold_full_r || grant_r);
      overrun_l = i_left_valid  && hold_full_l && !grant_l;
      overrun_r = i_right_valid && hold_full_r && !grant_r;
   end

   // Channel holding registers: a capture wins over the drain of the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_full_l <= 1'b0;
         hold_full_r <= 1'b0;
         hold_data_l <= '0;
         hold_data_r <= '0;
      end else begin
         if (capture_l) begin
            hold_full_l <= 1'b1;
            hold_data_l <= i_left_sample;
         end else if (grant_l) begin
            hold_full_l <= 1'b0;
         end
         if (capture_r) begin
            hold_full_r <= 1'b1;
            hold_data_r <= i_right_sample;
         end else if (grant_r) begin
            hold_full_r <= 1'b0;
         end
      end
   end

   // Output register and round-robin pointer; the pointer moves only on a grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_if.o_valid   <= 1'b0;
         out_if.o_is_left <= 1'b0;
         out_if.o_value   <= '0;
         rr               <= 1'b0;
      end else if (grant_l) begin
         out_if.o_valid   <= 1'b1;
         out_if.o_is_left <= 1'b1;
         out_if.o_value   <= magnitude(hold_data_l);
         rr               <= 1'b1;
      end else if (grant_r) begin
         out_if.o_valid   <= 1'b1;
         out_if.o_is_left <= 1'b0;
         out_if.o_value   <= magnitude(hold_data_r);
         rr               <= 1'b0;
      end else if (slot_free) begin
         out_if.o_valid   <= 1'b0;
      end
   end

   // Saturating overrun counters; a clear never swallows a same-cycle overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_left  <= 8'd0;
         overrun_right <= 8'd0;
      end else begin
         if (overrun_clear)
            overrun_left <= overrun_l ? 8'd1 : 8'd0;
         else if (overrun_l && overrun_left != 8'hFF)
            overrun_left <= overrun_left + 8'd1;

         if (overrun_clear)
            overrun_right <= overrun_r ? 8'd1 : 8'd0;
         else if (overrun_r && overrun_right != 8'hFF)
            overrun_right <= overrun_right + 8'd1;
      end
   end

endmodule

// File: tb/tb_stereo_peak_sample_scheduler.sv
// Bench for stereo_peak_sample_scheduler: directed scenarios followed by a
// randomized run, with a queue-based scoreboard fed by a reference model.
module tb_stereo_peak_sample_scheduler;

   localparam int W = 15;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic          l_valid, r_valid, ov_clear, o_ready_tb;
   logic [W:0]    l_sample, r_sample;
   logic [7:0]    overrun_left, overrun_right;

   stereo_peak_sample_scheduler_if #(.width(W)) bus ();
   assign bus.o_ready = o_ready_tb;

   stereo_peak_sample_scheduler #(.width(W)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_left_valid   (l_valid),
      .i_left_sample  (l_sample),
      .i_right_valid  (r_valid),
      .i_right_sample (r_sample),
      .out_if         (bus),
      .overrun_clear  (ov_clear),
      .overrun_left   (overrun_left),
      .overrun_right  (overrun_right)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int passes = 0;
   logic [W:0] exp_q[$];   // {is_left, magnitude}

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // One pending sample per channel, one output slot, a tie-break pointer.
   function automatic int ref_mag(input logic [W:0] s);
      int v;
      v = int'($signed(s));
      if (v < 0) v = -v;
      if (v > 32767) v = 32767;
      return v;
   endfunction

   bit          m_full_l, m_full_r, m_ovalid, m_right_turn;
   logic [W:0]  m_hold_l, m_hold_r;
   int          m_cnt_l, m_cnt_r;

   always @(posedge clk or posedge reset) begin
      bit free, gl, gr, ovl, ovr;
      if (reset) begin
         m_full_l = 0; m_full_r = 0; m_ovalid = 0; m_right_turn = 0;
         m_cnt_l = 0; m_cnt_r = 0;
         exp_q.delete();
      end else begin
         free = !m_ovalid || o_ready_tb;
         gl = 0; gr = 0;
         if (free && m_full_l && m_full_r) begin
            if (m_right_turn) gr = 1; else gl = 1;
         end else if (free && m_full_l) gl = 1;
         else if (free && m_full_r) gr = 1;

         if (gl) begin
            exp_q.push_back({1'b1, 15'(ref_mag(m_hold_l))});
            m_full_l = 0; m_right_turn = 1; m_ovalid = 1;
         end else if (gr) begin
            exp_q.push_back({1'b0, 15'(ref_mag(m_hold_r))});
            m_full_r = 0; m_right_turn = 0; m_ovalid = 1;
         end else if (free) begin
            m_ovalid = 0;
         end

         ovl = 0; ovr = 0;
         if (l_valid) begin
            if (m_full_l) ovl = 1;
            else begin m_full_l = 1; m_hold_l = l_sample; end
         end
         if (r_valid) begin
            if (m_full_r) ovr = 1;
            else begin m_full_r = 1; m_hold_r = r_sample; end
         end
         if (ov_clear) begin
            m_cnt_l = ovl ? 1 : 0;
            m_cnt_r = ovr ? 1 : 0;
         end else begin
            if (ovl && m_cnt_l < 255) m_cnt_l++;
            if (ovr && m_cnt_r < 255) m_cnt_r++;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   bit         stall_prev;
   logic       prev_is_left;
   logic [W-1:0] prev_value;

   always @(negedge clk) begin
      logic [W:0] exp;
      if (reset) begin
         stall_prev = 0;
      end else begin
         chk("o_valid", 32'(bus.o_valid), 32'(m_ovalid));
         chk("overrun_left", 32'(overrun_left), 32'(m_cnt_l));
         chk("overrun_right", 32'(overrun_right), 32'(m_cnt_r));
         if (stall_prev) begin
            chk("stall_is_left", 32'(bus.o_is_left), 32'(prev_is_left));
            chk("stall_value", 32'(bus.o_value), 32'(prev_value));
         end
         if (bus.o_valid && o_ready_tb) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 32'(1), 32'(0));
            end else begin
               exp = exp_q.pop_front();
               chk("xfer_is_left", 32'(bus.o_is_left), 32'(exp[W]));
               chk("xfer_value", 32'(bus.o_value), 32'(exp[W-1:0]));
            end
         end
         stall_prev   = bus.o_valid && !o_ready_tb;
         prev_is_left = bus.o_is_left;
         prev_value   = bus.o_value;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic lv, input logic [W:0] ls,
                         input logic rv, input logic [W:0] rs);
      l_valid = lv; l_sample = ls;
      r_valid = rv; r_sample = rs;
      step();
      l_valid = 0; r_valid = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   function automatic logic [W:0] rand_sample();
      case ($urandom_range(0, 7))
         0: return 16'h8000;
         1: return 16'h7FFF;
         2: return 16'h0000;
         3: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      reset = 1; l_valid = 0; r_valid = 0; ov_clear = 0; o_ready_tb = 1;
      l_sample = '0; r_sample = '0;
      repeat (3) @(posedge clk);
      #1 reset = 0;

      chk("rst_valid", 32'(bus.o_valid), 0);
      chk("rst_is_left", 32'(bus.o_is_left), 0);
      chk("rst_value", 32'(bus.o_value), 0);
      chk("rst_ovl", 32'(overrun_left), 0);
      chk("rst_ovr", 32'(overrun_right), 0);

      // single left strobe of -200
      strobe(1, 16'hFF38, 0, 0);
      step();
      chk("t1_valid", 32'(bus.o_valid), 1);
      chk("t1_is_left", 32'(bus.o_is_left), 1);
      chk("t1_value", 32'(bus.o_value), 200);
      step();
      chk("t1_valid_drop", 32'(bus.o_valid), 0);

      // simultaneous strobes right after reset: left first
      do_reset();
      strobe(1, 16'd1000, 1, 16'hFC18);
      chk("t2_nobypass", 32'(bus.o_valid), 0);
      step();
      chk("t2a_is_left", 32'(bus.o_is_left), 1);
      chk("t2a_value", 32'(bus.o_value), 1000);
      step();
      chk("t2b_is_left", 32'(bus.o_is_left), 0);
      chk("t2b_value", 32'(bus.o_value), 1000);
      step();
      // one extra left grant moves the pointer to right
      strobe(1, 16'd5, 0, 0);
      step(); step();
      strobe(1, 16'd7, 1, 16'd9);
      step();
      chk("t2c_is_left", 32'(bus.o_is_left), 0);
      chk("t2c_value", 32'(bus.o_value), 9);
      step();
      chk("t2d_is_left", 32'(bus.o_is_left), 1);
      chk("t2d_value", 32'(bus.o_value), 7);
      step(); step();

      // stalled output: first held in output, second in hold, third dropped
      o_ready_tb = 0;
      strobe(1, 16'd100, 0, 0);
      step();
      strobe(1, 16'd200, 0, 0);
      step();
      strobe(1, 16'd300, 0, 0);
      repeat (5) step();
      chk("t3_valid", 32'(bus.o_valid), 1);
      chk("t3_value", 32'(bus.o_value), 100);
      chk("t3_ovl", 32'(overrun_left), 1);
      o_ready_tb = 1;
      step();
      chk("t3_second", 32'(bus.o_value), 200);
      step();
      chk("t3_empty", 32'(bus.o_valid), 0);

      // magnitude corners on right
      strobe(0, 0, 1, 16'h8000);
      step();
      chk("t4_8000", 32'(bus.o_value), 32'h7FFF);
      chk("t4_is_right", 32'(bus.o_is_left), 0);
      strobe(0, 0, 1, 16'h7FFF);
      step();
      chk("t4_7fff", 32'(bus.o_value), 32'h7FFF);
      strobe(0, 0, 1, 16'h0000);
      step();
      chk("t4_zero", 32'(bus.o_value), 0);
      step();

      // overrun saturation and clear-with-overrun
      ov_clear = 1; step(); ov_clear = 0;
      o_ready_tb = 0;
      for (int i = 0; i < 302; i++) strobe(1, rand_sample(), 0, 0);
      chk("t5_sat", 32'(overrun_left), 255);
      l_valid = 1; l_sample = 16'd1; ov_clear = 1;
      step();
      l_valid = 0; ov_clear = 0;
      chk("t5_clear_ov", 32'(overrun_left), 1);
      chk("t5_right_zero", 32'(overrun_right), 0);
      o_ready_tb = 1;
      repeat (4) step();

      // reset mid-operation with output valid and both holds full
      o_ready_tb = 0;
      strobe(1, 16'd11, 0, 0);
      step();
      strobe(1, 16'd22, 1, 16'd33);
      step();
      #2 reset = 1;
      #1;
      chk("t6_valid", 32'(bus.o_valid), 0);
      chk("t6_is_left", 32'(bus.o_is_left), 0);
      chk("t6_value", 32'(bus.o_value), 0);
      chk("t6_ovl", 32'(overrun_left), 0);
      chk("t6_ovr", 32'(overrun_right), 0);
      step();
      reset = 0;
      o_ready_tb = 1;
      strobe(0, 0, 1, 16'd77);
      step();
      chk("t6_first_right", 32'(bus.o_is_left), 0);
      chk("t6_first_value", 32'(bus.o_value), 77);
      step();
      chk("t6_no_stale", 32'(bus.o_valid), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         l_valid    = ($urandom_range(0, 2) == 0);
         r_valid    = ($urandom_range(0, 2) == 0);
         l_sample   = rand_sample();
         r_sample   = rand_sample();
         o_ready_tb = ($urandom_range(0, 3) != 0);
         ov_clear   = ($urandom_range(0, 99) == 0);
         step();
      end
      l_valid = 0; r_valid = 0; ov_clear = 0; o_ready_tb = 1;
      repeat (10) step();
      chk("drain_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
